ddr_port_arbiter: RTL and testbench
===================================

# ddr_port_arbiter

Shares one DDR4 user command/data port among `REQ_NUM` on-chip requesters, such as the feature loader, weight loader, gradient writer and output writer. Commands are granted round-robin. A write holds the port until its last data beat. Read returns are steered back to the issuing requester in order, using an outstanding-read ID FIFO. One instance sits in `fpga_top` between the training datapath and each DDR4 wrapper; commands are held off until that wrapper reports `init_calib_complete`.

## Interface
- `REQ_NUM`, 4, number of requesters
- `ADDR_W`, 32, byte address width
- `LEN_W`, 8, burst length field; value = beats-1
- `DATA_W`, 512, beat width
- `RD_OUT`, 8, max outstanding read bursts (power of 2)
- `clk`  in  1  sole clock
- `rst`  in  1  asynchronous, active-high reset
- `calib_done`  in  1  DDR `init_calib_complete`
- `req_valid`/`req_ready`  in/out  REQ_NUM  per-requester command handshake
- `req_wr`  in  REQ_NUM  1 = write, 0 = read
- `req_addr`  in  REQ_NUM*ADDR_W  packed addresses, requester i at `[i*ADDR_W +: ADDR_W]`
- `req_len`  in  REQ_NUM*LEN_W  packed lengths
- `req_wdata`  in  REQ_NUM*DATA_W  packed write beats
- `req_wvalid`/`req_wready`  in/out  REQ_NUM  write-beat handshake
- `rsp_rdata`  out  DATA_W  read beat, common to all requesters
- `rsp_rvalid`  out  REQ_NUM  one-hot; marks the owner of `rsp_rdata`
- `rsp_rlast`  out  1  last beat of a read burst
- `mem_cmd_valid`/`mem_cmd_ready`  out/in  1  memory command handshake
- `mem_cmd_wr` out 1, `mem_cmd_addr` out ADDR_W, `mem_cmd_len` out LEN_W  command fields
- `mem_wdata` out DATA_W, `mem_wvalid` out 1, `mem_wlast` out 1, `mem_wready` in 1  write data channel
- `mem_rdata` in DATA_W, `mem_rvalid` in 1, `mem_rlast` in 1  read data channel; no backpressure
- `rd_err`  out  1  sticky; set by read data arriving with no outstanding ID

## Operation
- **FSM states:** IDLE, ARB, CMD, WDATA.
- **IDLE:** wait for `calib_done`=1, then go to ARB. Calibration is latched once seen; a later drop of `calib_done` is ignored.
- **Eligibility in ARB:** requester i is eligible if `req_valid[i]` is set and either `req_wr[i]` is set or the ID FIFO count is below `RD_OUT`.
- **Grant selection:** search starts at index `last+1` and wraps modulo `REQ_NUM`. The first eligible index g wins.
- **Grant action:** `req_ready[g]`=1 combinationally for that one cycle. Command fields are registered into `mem_cmd_*`, g is stored as `last`, and the FSM goes to CMD. With no eligible requester, the FSM stays in ARB.
- **CMD:** `mem_cmd_valid`=1 until `mem_cmd_ready`. On the handshake:
  - write: clear the beat counter and go to WDATA;
  - read: push g into the ID FIFO and go to ARB.
- **WDATA:**
  - data path: `mem_wdata`=`req_wdata[g]`, `mem_wvalid`=`req_wvalid[g]`, `req_wready[g]`=`mem_wready`; all other `req_wready` bits are 0;
  - `mem_wlast` = (counter == latched len); the counter increments on each beat handshake;
  - the last-beat handshake returns the FSM to ARB;
  - no command is issued while in WDATA.
- **Read return (independent of the FSM):**
  - with the FIFO non-empty: `rsp_rdata`=`mem_rdata`, `rsp_rlast`=`mem_rlast`, and `rsp_rvalid`=one-hot(FIFO head) when `mem_rvalid`=1;
  - `mem_rvalid && mem_rlast` pops the FIFO;
  - a simultaneous push and pop leaves the count unchanged;
  - `mem_rvalid` with an empty FIFO: the beat is dropped, `rsp_rvalid`=0, and `rd_err` is set until reset.
- **Reset:** `rst` asserted at any time forces IDLE immediately. It also empties the FIFO and drops any in-flight burst; requesters must re-issue.

## Timing
- **Reset values:** all outputs 0, `rd_err`=0, FIFO empty, `last`=`REQ_NUM-1` (requester 0 has first priority).
- **Command path:** `req_ready` pulse in cycle N; `mem_cmd_valid` rises in cycle N+1. Best-case throughput is 1 command per 2 cycles.
- **Read return:** combinational, 0 cycles from `mem_*` to `rsp_*`.
- **Write data:** combinational pass-through, 0 cycles; there are no internal data buffers.
- **Outstanding-read limit:** a read is not granted when count == `RD_OUT`. This holds even if a pop happens in the same cycle, because eligibility uses the registered count.
- **Width rules:** the beat counter is LEN_W bits; the FIFO count is log2(RD_OUT)+1 bits.

## Test plan
- **Calibration hold-off:** `calib_done`=0 with `req_valid`=4'b1111 held -> no `req_ready` and no `mem_cmd_valid`. Raise `calib_done` -> first grant goes to requester 0, then 1, 2, 3 in order.
- **Write burst:** requester 2 writes len=3 to address 0x1000 with `mem_wready` toggling every cycle -> 4 beats forwarded, `mem_wlast` on the 4th beat only. A read from requester 0 pending during the burst is not granted until the burst ends.
- **Outstanding-read limit:** 9 single-beat reads from mixed requesters with `mem_rvalid` held low -> 8 commands issued, the 9th not granted. One returned beat (`rlast`=1) -> the 9th is granted.
- **Read steering:** reads issued by requesters 3, 1, 3 with len 0, 1, 0 -> `rsp_rvalid` sequence 4'b1000, 4'b0010, 4'b0010, 4'b1000, with `rsp_rlast` set on beats 1, 3 and 4.
- **Unexpected read data:** `mem_rvalid`=1 with an empty FIFO -> `rd_err`=1 and stays set; `rsp_rvalid`=0.
- **Reset mid-burst:** assert `rst` during WDATA beat 2 of 8 -> all outputs 0 immediately. After release and calibration, the next grant goes to requester 0.

Source files
------------

// File: rtl/ddr_port_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ddr_port_arbiter_if                                                        |
// | Requester-side and memory-side signal bundle of the DDR port arbiter.     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
interface ddr_port_arbiter_if #(
   parameter int REQ_NUM = 4,
   parameter int ADDR_W  = 32,
   parameter int LEN_W   = 8,
   parameter int DATA_W  = 512
);
   logic                      calib_done;

   logic [REQ_NUM-1:0]        req_valid;
   logic [REQ_NUM-1:0]        req_ready;
   logic [REQ_NUM-1:0]        req_wr;
   logic [REQ_NUM*ADDR_W-1:0] req_addr;
   logic [REQ_NUM*LEN_W-1:0]  req_len;
   logic [REQ_NUM*DATA_W-1:0] req_wdata;
   logic [REQ_NUM-1:0]        req_wvalid;
   logic [REQ_NUM-1:0]        req_wready;

   logic [DATA_W-1:0]         rsp_rdata;
   logic [REQ_NUM-1:0]        rsp_rvalid;
   logic                      rsp_rlast;

   logic                      mem_cmd_valid;
   logic                      mem_cmd_ready;
   logic                      mem_cmd_wr;
   logic [ADDR_W-1:0]         mem_cmd_addr;
   logic [LEN_W-1:0]          mem_cmd_len;
   logic [DATA_W-1:0]         mem_wdata;
   logic                      mem_wvalid;
   logic                      mem_wlast;
   logic                      mem_wready;
   logic [DATA_W-1:0]         mem_rdata;
   logic                      mem_rvalid;
   logic                      mem_rlast;

   logic                      rd_err;

   modport slave (
      input  calib_done,
      input  req_valid, req_wr, req_addr, req_len, req_wdata, req_wvalid,
      output req_ready, req_wready,
      output rsp_rdata, rsp_rvalid, rsp_rlast,
      output mem_cmd_valid, mem_cmd_wr, mem_cmd_addr, mem_cmd_len,
      input  mem_cmd_ready,
      output mem_wdata, mem_wvalid, mem_wlast,
      input  mem_wready,
      input  mem_rdata, mem_rvalid, mem_rlast,
      output rd_err
   );

   modport master (
      output calib_done,
      output req_valid, req_wr, req_addr, req_len, req_wdata, req_wvalid,
      input  req_ready, req_wready,
      input  rsp_rdata, rsp_rvalid, rsp_rlast,
      input  mem_cmd_valid, mem_cmd_wr, mem_cmd_addr, mem_cmd_len,
      output mem_cmd_ready,
      input  mem_wdata, mem_wvalid, mem_wlast,
      output mem_wready,
      output mem_rdata, mem_rvalid, mem_rlast,
      input  rd_err
   );
endinterface
`default_nettype wire

// File: rtl/ddr_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ddr_port_arbiter                                                           |
// | Round-robin sharing of one DDR user port; reads steered back via ID FIFO. |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module ddr_port_arbiter #(
   parameter int REQ_NUM = 4,
   parameter int ADDR_W  = 32,
   parameter int LEN_W   = 8,
   parameter int DATA_W  = 512,
   parameter int RD_OUT  = 8
) (
   input  wire logic          clk,
   input  wire logic          rst,
   ddr_port_arbiter_if.slave  bus
);
   localparam int c_IDX_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
   localparam int c_PTR_W = (RD_OUT > 1) ? $clog2(RD_OUT) : 1;
   localparam int c_CNT_W = c_PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARB   = 2'd1,
      CMD   = 2'd2,
      WDATA = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;

   logic [c_IDX_W-1:0]   r_last;
   logic [c_IDX_W-1:0]   r_gnt;
   logic                 r_cmd_wr;
   logic [ADDR_W-1:0]    r_cmd_addr;
   logic [LEN_W-1:0]     r_cmd_len;
   logic [LEN_W-1:0]     r_beat;
   logic                 r_rd_err;

   logic [c_IDX_W-1:0]   r_fifo [RD_OUT];
   logic [c_PTR_W-1:0]   r_wptr;
   logic [c_PTR_W-1:0]   r_rptr;
   logic [c_CNT_W-1:0]   r_cnt;

   logic [REQ_NUM-1:0]   w_elig;
   logic                 w_room;
   logic                 w_found;
   logic [c_IDX_W-1:0]   w_gnt_idx;
   logic [c_IDX_W:0]     w_cand;
   logic                 w_grant;
   logic                 w_cmd_hs;
   logic                 w_beat_hs;
   logic                 w_wlast;
   logic                 w_sel_wvalid;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_fifo_nz;
   logic [c_IDX_W-1:0]   w_head;

   // Eligibility uses the registered count, so a same-cycle pop never frees a slot early.
   assign w_room = (r_cnt < c_CNT_W'(RD_OUT));
   assign w_elig = bus.req_valid & (bus.req_wr | {REQ_NUM{w_room}});

   always_comb begin
      w_found   = 1'b0;
      w_gnt_idx = '0;
      w_cand    = '0;
      for (int k = 1; k <= REQ_NUM; k++) begin
         w_cand = {1'b0, r_last} + (c_IDX_W + 1)'(k);
         if (w_cand >= (c_IDX_W + 1)'(REQ_NUM)) begin
            w_cand = w_cand - (c_IDX_W + 1)'(REQ_NUM);
         end
         if (!w_found && w_elig[w_cand[c_IDX_W-1:0]]) begin
            w_found   = 1'b1;
            w_gnt_idx = w_cand[c_IDX_W-1:0];
         end
      end
   end

   assign w_wlast      = (r_beat == r_cmd_len);
   assign w_sel_wvalid = bus.req_wvalid[r_gnt];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_grant           = 1'b0;
      w_cmd_hs          = 1'b0;
      w_beat_hs         = 1'b0;
      bus.req_ready     = '0;
      bus.req_wready    = '0;
      bus.mem_cmd_valid = 1'b0;
      bus.mem_wdata     = '0;
      bus.mem_wvalid    = 1'b0;
      bus.mem_wlast     = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.calib_done) begin
               w_state_nxt = ARB;
            end
         end
         ARB: begin
            if (w_found) begin
               w_grant                  = 1'b1;
               bus.req_ready[w_gnt_idx] = 1'b1;
               w_state_nxt              = CMD;
            end
         end
         CMD: begin
            bus.mem_cmd_valid = 1'b1;
            if (bus.mem_cmd_ready) begin
               w_cmd_hs    = 1'b1;
               w_state_nxt = r_cmd_wr ? WDATA : ARB;
            end
         end
         WDATA: begin
            bus.mem_wdata         = bus.req_wdata[r_gnt*DATA_W +: DATA_W];
            bus.mem_wvalid        = w_sel_wvalid;
            bus.mem_wlast         = w_wlast;
            bus.req_wready[r_gnt] = bus.mem_wready;
            if (w_sel_wvalid && bus.mem_wready) begin
               w_beat_hs = 1'b1;
               if (w_wlast) begin
                  w_state_nxt = ARB;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last     <= c_IDX_W'(REQ_NUM - 1);
         r_gnt      <= '0;
         r_cmd_wr   <= 1'b0;
         r_cmd_addr <= '0;
         r_cmd_len  <= '0;
         r_beat     <= '0;
      end else begin
         if (w_grant) begin
            r_gnt      <= w_gnt_idx;
            r_last     <= w_gnt_idx;
            r_cmd_wr   <= bus.req_wr[w_gnt_idx];
            r_cmd_addr <= bus.req_addr[w_gnt_idx*ADDR_W +: ADDR_W];
            r_cmd_len  <= bus.req_len[w_gnt_idx*LEN_W +: LEN_W];
         end
         if (w_cmd_hs) begin
            r_beat <= '0;
         end else if (w_beat_hs) begin
            r_beat <= r_beat + LEN_W'(1);
         end
      end
   end

   assign bus.mem_cmd_wr   = r_cmd_wr;
   assign bus.mem_cmd_addr = r_cmd_addr;
   assign bus.mem_cmd_len  = r_cmd_len;

   // Outstanding-read ID FIFO: one entry per read burst, popped on its last beat.
   assign w_push    = w_cmd_hs && !r_cmd_wr;
   assign w_fifo_nz = (r_cnt != '0);
   assign w_pop     = bus.mem_rvalid && bus.mem_rlast && w_fifo_nz;
   assign w_head    = r_fifo[r_rptr];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo[r_wptr] <= r_gnt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_cnt    <= '0;
         r_rd_err <= 1'b0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + c_PTR_W'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + c_PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + c_CNT_W'(1);
            2'b01:   r_cnt <= r_cnt - c_CNT_W'(1);
            default: r_cnt <= r_cnt;
         endcase
         if (bus.mem_rvalid && !w_fifo_nz) begin
            r_rd_err <= 1'b1;
         end
      end
   end

   assign bus.rsp_rdata  = w_fifo_nz ? bus.mem_rdata : '0;
   assign bus.rsp_rlast  = w_fifo_nz ? bus.mem_rlast : 1'b0;
   assign bus.rsp_rvalid = (w_fifo_nz && bus.mem_rvalid)
                         ? ({{(REQ_NUM-1){1'b0}}, 1'b1} << w_head) : '0;
   assign bus.rd_err     = r_rd_err;

endmodule
`default_nettype wire

// File: tb/tb_ddr_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ddr_port_arbiter                                                        |
// | Directed scoreboard bench for the DDR port arbiter.                       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_ddr_port_arbiter;
   localparam int REQ_NUM = 4;
   localparam int ADDR_W  = 32;
   localparam int LEN_W   = 8;
   localparam int DATA_W  = 512;
   localparam int RD_OUT  = 8;
   localparam int c_CW    = 600;

   typedef logic [c_CW-1:0] cw_t;
   typedef struct { int idx; bit wdone; } gnt_t;
   typedef struct { logic wr; logic [ADDR_W-1:0] addr; logic [LEN_W-1:0] len; } cmd_t;
   typedef struct { logic [DATA_W-1:0] data; logic last; } wbt_t;
   typedef struct { logic [REQ_NUM-1:0] oh; logic last; logic [DATA_W-1:0] data; } rsp_t;

   logic clk;
   logic rst;

   ddr_port_arbiter_if #(.REQ_NUM(REQ_NUM), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W)) bus ();

   ddr_port_arbiter #(
      .REQ_NUM(REQ_NUM), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W), .RD_OUT(RD_OUT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   gnt_t exp_g [$];
   cmd_t exp_c [$];
   wbt_t exp_w [$];
   rsp_t exp_r [$];

   int               wbeat [REQ_NUM];
   int               wlen  [REQ_NUM];
   logic [REQ_NUM-1:0] s_ready;
   logic [REQ_NUM-1:0] s_whs;
   bit               wr_toggle = 1'b0;

   task automatic chk(input string name, input cw_t act, input cw_t exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input cw_t act);
      n_vec++;
      n_err++;
      $display("FAIL %s: got %0h expected nothing", name, act);
   endtask

   function automatic logic [DATA_W-1:0] wpat(input int r, input int k);
      logic [31:0] w;
      w = 32'hA000_0000 | 32'(r << 8) | 32'(k);
      return {16{w}};
   endfunction

   function automatic logic [DATA_W-1:0] rpat(input int n);
      logic [31:0] w;
      w = 32'hB000_0000 | 32'(n);
      return {16{w}};
   endfunction

   // Monitor: every DUT-presented event pops its expected entry.
   gnt_t               m_g;
   cmd_t               m_c;
   wbt_t               m_w;
   rsp_t               m_r;
   logic [REQ_NUM-1:0] one4 = 4'b0001;

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.req_ready != '0) begin
            if (exp_g.size() == 0) fail_now("grant_unexpected", cw_t'(bus.req_ready));
            else begin
               m_g = exp_g.pop_front();
               chk("grant", cw_t'(bus.req_ready), cw_t'(one4 << m_g.idx));
               if (m_g.wdone) chk("grant_after_burst", cw_t'(exp_w.size()), cw_t'(0));
            end
         end
         if (bus.mem_cmd_valid && bus.mem_cmd_ready) begin
            if (exp_c.size() == 0) fail_now("cmd_unexpected", cw_t'(bus.mem_cmd_addr));
            else begin
               m_c = exp_c.pop_front();
               chk("cmd", cw_t'({bus.mem_cmd_wr, bus.mem_cmd_addr, bus.mem_cmd_len}),
                   cw_t'({m_c.wr, m_c.addr, m_c.len}));
            end
         end
         if (bus.mem_wvalid && bus.mem_wready) begin
            if (exp_w.size() == 0) fail_now("wbeat_unexpected", cw_t'(bus.mem_wdata));
            else begin
               m_w = exp_w.pop_front();
               chk("wbeat", cw_t'({bus.mem_wlast, bus.mem_wdata}), cw_t'({m_w.last, m_w.data}));
            end
         end
         if (bus.rsp_rvalid != '0) begin
            if (exp_r.size() == 0) fail_now("rsp_unexpected", cw_t'(bus.rsp_rvalid));
            else begin
               m_r = exp_r.pop_front();
               chk("rsp", cw_t'({bus.rsp_rvalid, bus.rsp_rlast, bus.rsp_rdata}),
                   cw_t'({m_r.oh, m_r.last, m_r.data}));
            end
         end
      end
   end

   // One cycle: sample at negedge, then update requester models just after posedge.
   task automatic tick();
      @(negedge clk);
      s_ready = bus.req_ready;
      s_whs   = bus.req_wready & bus.req_wvalid;
      @(posedge clk);
      #1;
      bus.req_valid = bus.req_valid & ~s_ready;
      for (int i = 0; i < REQ_NUM; i++) begin
         if (s_whs[i]) begin
            wbeat[i]++;
            if (wbeat[i] > wlen[i]) bus.req_wvalid[i] = 1'b0;
            else bus.req_wdata[i*DATA_W +: DATA_W] = wpat(i, wbeat[i]);
         end
      end
      if (wr_toggle) bus.mem_wready = ~bus.mem_wready;
   endtask

   task automatic issue(input int r, input bit wr, input logic [ADDR_W-1:0] addr,
                        input logic [LEN_W-1:0] len, input bit wdone);
      exp_g.push_back('{idx: r, wdone: wdone});
      exp_c.push_back('{wr: wr, addr: addr, len: len});
      bus.req_wr[r]                      = wr;
      bus.req_addr[r*ADDR_W +: ADDR_W]   = addr;
      bus.req_len[r*LEN_W +: LEN_W]      = len;
      if (wr) begin
         for (int k = 0; k <= int'(len); k++)
            exp_w.push_back('{data: wpat(r, k), last: (k == int'(len))});
         wbeat[r] = 0;
         wlen[r]  = int'(len);
         bus.req_wdata[r*DATA_W +: DATA_W] = wpat(r, 0);
         bus.req_wvalid[r] = 1'b1;
      end
      bus.req_valid[r] = 1'b1;
   endtask

   task automatic wait_gnt(input int r);
      for (int t = 0; t < 60 && bus.req_valid[r]; t++) tick();
      if (bus.req_valid[r]) fail_now("grant_timeout", cw_t'(r));
   endtask

   task automatic drain();
      for (int t = 0; t < 100 && (exp_g.size() + exp_c.size() + exp_w.size() + exp_r.size()) != 0; t++)
         tick();
      chk("drain_empty", cw_t'(exp_g.size() + exp_c.size() + exp_w.size() + exp_r.size()), cw_t'(0));
   endtask

   task automatic rbeat(input logic [REQ_NUM-1:0] oh, input bit last, input int n);
      if (oh != '0) exp_r.push_back('{oh: oh, last: last, data: rpat(n)});
      bus.mem_rvalid = 1'b1;
      bus.mem_rlast  = last;
      bus.mem_rdata  = rpat(n);
      tick();
      bus.mem_rvalid = 1'b0;
      bus.mem_rlast  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   logic [REQ_NUM-1:0] rd_seq [8] = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0};

   initial begin
      for (int i = 0; i < REQ_NUM; i++) begin
         wbeat[i] = 0;
         wlen[i]  = 0;
      end
      rst               = 1'b1;
      bus.calib_done    = 1'b1;
      bus.req_valid     = '1;
      bus.req_wr        = '0;
      bus.req_addr      = '0;
      bus.req_len       = '0;
      bus.req_wdata     = '0;
      bus.req_wvalid    = '0;
      bus.mem_cmd_ready = 1'b1;
      bus.mem_wready    = 1'b0;
      bus.mem_rdata     = '0;
      bus.mem_rvalid    = 1'b0;
      bus.mem_rlast     = 1'b0;

      // Reset state, with requests and calibration already present.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready",  cw_t'(bus.req_ready),     cw_t'(0));
      chk("rst_cmd_valid",  cw_t'(bus.mem_cmd_valid), cw_t'(0));
      chk("rst_cmd_fields", cw_t'({bus.mem_cmd_wr, bus.mem_cmd_addr, bus.mem_cmd_len}), cw_t'(0));
      chk("rst_wvalid",     cw_t'({bus.mem_wvalid, bus.mem_wlast, bus.req_wready}), cw_t'(0));
      chk("rst_rsp",        cw_t'({bus.rsp_rvalid, bus.rsp_rlast}), cw_t'(0));
      chk("rst_rd_err",     cw_t'(bus.rd_err),        cw_t'(0));

      // Calibration hold-off, then round-robin from requester 0.
      bus.req_valid  = '0;
      bus.calib_done = 1'b0;
      for (int i = 0; i < REQ_NUM; i++) issue(i, 1'b0, ADDR_W'(32'h100 * i), '0, 1'b0);
      rst = 1'b0;
      for (int t = 0; t < 5; t++) begin
         tick();
         chk("holdoff_ready", cw_t'(s_ready), cw_t'(0));
         chk("holdoff_cmd", cw_t'(bus.mem_cmd_valid), cw_t'(0));
      end
      bus.calib_done = 1'b1;
      drain();
      bus.calib_done = 1'b0;
      rbeat(4'b0001, 1'b1, 0);
      rbeat(4'b0010, 1'b1, 1);
      rbeat(4'b0100, 1'b1, 2);
      rbeat(4'b1000, 1'b1, 3);
      drain();

      // Write burst with toggling wready; a read from requester 0 waits for it.
      wr_toggle = 1'b1;
      issue(2, 1'b1, 32'h1000, 8'd3, 1'b0);
      wait_gnt(2);
      issue(0, 1'b0, 32'h40, 8'd0, 1'b1);
      drain();
      wr_toggle      = 1'b0;
      bus.mem_wready = 1'b1;
      rbeat(4'b0001, 1'b1, 10);
      drain();

      // Outstanding-read limit.
      for (int n = 0; n < 8; n++) begin
         issue(int'(rd_seq[n]), 1'b0, ADDR_W'(32'h2000 + 32'h40 * n), '0, 1'b0);
         wait_gnt(int'(rd_seq[n]));
      end
      bus.req_wr[1]                   = 1'b0;
      bus.req_addr[1*ADDR_W +: ADDR_W] = 32'h3000;
      bus.req_len[1*LEN_W +: LEN_W]    = '0;
      bus.req_valid[1]                = 1'b1;
      for (int t = 0; t < 6; t++) begin
         tick();
         chk("full_no_grant", cw_t'(s_ready), cw_t'(0));
      end
      exp_g.push_back('{idx: 1, wdone: 1'b0});
      exp_c.push_back('{wr: 1'b0, addr: 32'h3000, len: '0});
      rbeat(4'b0010, 1'b1, 20);
      wait_gnt(1);
      for (int n = 1; n < 8; n++) rbeat(one4 << rd_seq[n], 1'b1, 20 + n);
      rbeat(4'b0010, 1'b1, 28);
      drain();

      // Read steering: 3 (len0), 1 (len1), 3 (len0).
      issue(3, 1'b0, 32'h4000, 8'd0, 1'b0);
      wait_gnt(3);
      issue(1, 1'b0, 32'h4100, 8'd1, 1'b0);
      wait_gnt(1);
      issue(3, 1'b0, 32'h4200, 8'd0, 1'b0);
      wait_gnt(3);
      drain();
      rbeat(4'b1000, 1'b1, 30);
      rbeat(4'b0010, 1'b0, 31);
      rbeat(4'b0010, 1'b1, 32);
      rbeat(4'b1000, 1'b1, 33);
      drain();

      // Unexpected read data.
      chk("rd_err_clear", cw_t'(bus.rd_err), cw_t'(0));
      bus.mem_rvalid = 1'b1;
      bus.mem_rlast  = 1'b1;
      bus.mem_rdata  = rpat(40);
      #1;
      chk("unexp_rsp_rvalid", cw_t'(bus.rsp_rvalid), cw_t'(0));
      tick();
      bus.mem_rvalid = 1'b0;
      bus.mem_rlast  = 1'b0;
      chk("rd_err_set", cw_t'(bus.rd_err), cw_t'(1));
      repeat (3) tick();
      chk("rd_err_sticky", cw_t'(bus.rd_err), cw_t'(1));

      // Reset during the second beat of an 8-beat write.
      issue(1, 1'b1, 32'h5000, 8'd7, 1'b0);
      wait_gnt(1);
      for (int t = 0; t < 20 && wbeat[1] < 1; t++) tick();
      rst            = 1'b1;
      bus.calib_done = 1'b0;
      #1;
      chk("midrst_wr_outputs", cw_t'({bus.mem_wvalid, bus.mem_wlast, bus.req_wready}), cw_t'(0));
      chk("midrst_wdata", cw_t'(bus.mem_wdata), cw_t'(0));
      chk("midrst_cmd", cw_t'({bus.mem_cmd_valid, bus.mem_cmd_wr, bus.mem_cmd_addr, bus.mem_cmd_len}), cw_t'(0));
      chk("midrst_rd_err", cw_t'(bus.rd_err), cw_t'(0));
      chk("midrst_beats_left", cw_t'(exp_w.size()), cw_t'(7));
      exp_w.delete();
      bus.req_wvalid = '0;
      repeat (2) tick();
      rst = 1'b0;
      issue(0, 1'b0, 32'h6000, 8'd0, 1'b0);
      issue(3, 1'b0, 32'h6300, 8'd0, 1'b0);
      for (int t = 0; t < 2; t++) begin
         tick();
         chk("recal_no_grant", cw_t'(s_ready), cw_t'(0));
      end
      bus.calib_done = 1'b1;
      drain();
      rbeat(4'b0001, 1'b1, 50);
      rbeat(4'b1000, 1'b1, 51);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
